pixel_denormalizer: RTL and testbench
=====================================

// Module: pixel_denormalizer
// PURPOSE
//   Return path of the pixel normalizer. Converts signed fixed-point CNN activations
//   (Q8.8 normalizer format, sign-extended with guard bits) back to 8-bit unsigned pixels.
//   Sits at the tail of the accelerator, feeding the frame writeback/readout logic.
//   2-stage round/saturate pipeline, valid/ready backpressure, per-frame pixel counter,
//   saturation statistics.
// PARAMETERS
//   IN_W         18   input width, signed two's complement (default Q10.8)
//   FRAC_W       8    fractional bits in pixel_in; must satisfy 1 <= FRAC_W < IN_W
//   FRAME_PIXELS 784  pixels per frame (28x28); frame_done fires on the last one
//   CNT_W        16   width of sat_count
// PORTS
//   clk          in   1       single clock, rising edge
//   rst          in   1       reset: asynchronous, active-low (0 = reset)
//   pixel_in     in   IN_W    signed fixed-point activation
//   valid_in     in   1       pixel_in valid
//   ready_out    out  1       block can accept; transfer when valid_in && ready_out
//   pixel_out    out  8       unsigned rounded/saturated pixel
//   valid_out    out  1       pixel_out valid
//   ready_in     in   1       downstream ready; output transfer when valid_out && ready_in
//   frame_done   out  1       1-cycle pulse after the last output transfer of a frame
//   sat_count    out  CNT_W   outputs clamped since reset/clear; sticks at all-ones
//   clear_stats  in   1       synchronous clear of sat_count and the frame pixel counter
// BEHAVIOUR
//   Clock/reset: one clock; reset is asynchronous and active-low.
//   Reset: pixel_out=0, valid_out=0, frame_done=0, sat_count=0, pixel ctr=0,
//     internal valids=0. In-flight data is discarded. ready_out=1 after reset.
//   Pipeline: en = !valid_out || ready_in; ready_out = en (combinational).
//     All stages advance only when en=1; when en=0 every stage holds.
//   S1 (round): sum = pixel_in + 2^(FRAC_W-1) at IN_W+1 bits signed;
//     q = sum >>> FRAC_W (arithmetic). Round-half-up; never overflows.
//   S2 (saturate): q<0 -> 0, sat=1; q>255 -> 255, sat=1; else q[7:0], sat=0.
//     Result registers into pixel_out/valid_out.
//   Latency: an input accepted in cycle N appears on pixel_out in cycle N+2
//     when ready_in stays 1. Throughput: 1 pixel/clk.
//   Backpressure: while valid_out && !ready_in, pixel_out is held stable and
//     no input is accepted. Bubbles (valid_in=0) propagate as valid=0.
//   Stats update only on an output transfer (valid_out && ready_in):
//     sat_count += sat of that pixel, holding at 2^CNT_W-1; pixel ctr += 1.
//   Frame: on the output transfer with pixel ctr == FRAME_PIXELS-1, ctr wraps
//     to 0 and frame_done=1 on the next cycle only.
//   clear_stats: next cycle sat_count=0 and pixel ctr=0. It overrides a
//     same-cycle transfer (that pixel is not counted; no frame_done from it).
//     The data path is unaffected.
// TESTING
//   1 Reset, stream 0x00040 (0.25), 0x00080 (0.5), 0x04000 (64.0), 0x04080 (64.5)
//     with ready_in=1 -> 0,1,64,65, each 2 cycles after acceptance; sat_count=0.
//   2 0x3FF00 (-1.0), 0x12C00 (300.0), 0x0FF7F (255.496), 0x0FF80 (255.5)
//     -> 0,255,255,255; sat_count=3 (only 0x0FF80 clamps among the last two).
//   3 Hold ready_in=0 for 5 cycles mid-stream -> pixel_out/valid_out stable,
//     ready_out=0; no pixel lost or duplicated after release (scoreboard).
//   4 Stream 784 pixels, then 1 more -> one frame_done pulse exactly 1 cycle
//     after the 784th output transfer; the 785th transfer does not pulse.
//   5 Assert clear_stats in the same cycle as an output transfer with sat=1
//     -> sat_count=0 next cycle; pixel counting restarts from that point.
//   6 Drop rst mid-stream with 2 pixels in flight -> valid_out=0 and
//     pixel_out=0 immediately (async); no stale output after rst returns to 1.

Source files
------------

// File: rtl/pixel_denormalizer.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_denormalizer
//  Description : Converts signed fixed-point activations back to 8-bit
//                unsigned pixels using a two-stage round/saturate pipeline.
//                Includes valid/ready backpressure, a per-frame pixel counter
//                with a frame_done pulse, and a sticky saturation counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_denormalizer #(
    parameter int IN_W         = 18,
    parameter int FRAC_W       = 8,
    parameter int FRAME_PIXELS = 784,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   pixel_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [7:0]        pixel_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              frame_done,
    output logic [CNT_W-1:0]  sat_count,
    input  logic              clear_stats
);

    // Width of the rounded integer part: one extra bit keeps the rounding
    // addition from ever overflowing.
    localparam int Q_W   = IN_W + 1 - FRAC_W;
    localparam int CTR_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

    localparam logic [IN_W:0]      c_half = {{IN_W{1'b0}}, 1'b1} << (FRAC_W - 1);
    localparam logic [CTR_W-1:0]   c_last = CTR_W'(FRAME_PIXELS - 1);

    logic               w_en;
    logic               w_xfer;
    logic [IN_W:0]      w_sum;
    logic [Q_W-1:0]     w_q;
    logic               w_neg;
    logic               w_big;
    logic [7:0]         w_mag;
    logic               w_sat;
    logic [7:0]         w_pix;

    logic               r_s1_valid;
    logic [Q_W-1:0]     r_s1_q;
    logic [7:0]         r_pixel_out;
    logic               r_valid_out;
    logic               r_sat;
    logic [CTR_W-1:0]   r_ctr;
    logic [CNT_W-1:0]   r_sat_count;
    logic               r_frame_done;

    // Whole pipeline advances together; it only stalls when the output
    // register is full and downstream refuses it.
    assign w_en      = !r_valid_out || ready_in;
    assign w_xfer    = r_valid_out && ready_in;
    assign ready_out = w_en;

    // Round half up: add one half LSB (sign-extended input), then take the
    // arithmetic right shift by the fraction width.
    assign w_sum = {pixel_in[IN_W-1], pixel_in} + c_half;
    assign w_q   = Q_W'($signed(w_sum) >>> FRAC_W);

    assign w_neg = r_s1_q[Q_W-1];

    generate
        if (Q_W > 9) begin : g_wide_q
            assign w_big = !w_neg && (|r_s1_q[Q_W-2:8]);
            assign w_mag = r_s1_q[7:0];
        end else begin : g_narrow_q
            // Non-negative range already fits in 8 bits; nothing to clamp high.
            assign w_big = 1'b0;
            assign w_mag = 8'(r_s1_q[Q_W-2:0]);
        end
    endgenerate

    assign w_sat = w_neg || w_big;
    assign w_pix = w_neg ? 8'd0 : (w_big ? 8'hFF : w_mag);

    // Round stage and saturate stage; data registers only load on valid
    // slots so the output bus stays quiet across bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_q      <= '0;
            r_valid_out <= 1'b0;
            r_pixel_out <= 8'd0;
            r_sat       <= 1'b0;
        end else if (w_en) begin
            r_s1_valid  <= valid_in;
            r_valid_out <= r_s1_valid;
            if (valid_in) begin
                r_s1_q <= w_q;
            end
            if (r_s1_valid) begin
                r_pixel_out <= w_pix;
                r_sat       <= w_sat;
            end
        end
    end

    // Statistics follow accepted outputs only; a clear wins over a
    // same-cycle transfer, which is then neither counted nor framed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctr        <= '0;
            r_sat_count  <= '0;
            r_frame_done <= 1'b0;
        end else if (clear_stats) begin
            r_ctr        <= '0;
            r_sat_count  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_xfer && (r_ctr == c_last);
            if (w_xfer) begin
                r_ctr <= (r_ctr == c_last) ? '0 : r_ctr + 1'b1;
                if (r_sat && (r_sat_count != {CNT_W{1'b1}})) begin
                    r_sat_count <= r_sat_count + 1'b1;
                end
            end
        end
    end

    assign pixel_out  = r_pixel_out;
    assign valid_out  = r_valid_out;
    assign frame_done = r_frame_done;
    assign sat_count  = r_sat_count;

endmodule
`default_nettype wire

// File: tb/tb_pixel_denormalizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_denormalizer
//  Description : Self-checking bench for pixel_denormalizer: directed vector
//                table plus hand-written stall, frame, clear and reset
//                sequences, with a scoreboard on the output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_denormalizer;

    localparam int IN_W         = 18;
    localparam int FRAC_W       = 8;
    localparam int FRAME_PIXELS = 784;
    localparam int CNT_W        = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [IN_W-1:0]   pixel_in;
    logic              valid_in;
    logic              ready_out;
    logic [7:0]        pixel_out;
    logic              valid_out;
    logic              ready_in;
    logic              frame_done;
    logic [CNT_W-1:0]  sat_count;
    logic              clear_stats;

    pixel_denormalizer #(
        .IN_W(IN_W), .FRAC_W(FRAC_W), .FRAME_PIXELS(FRAME_PIXELS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .valid_in(valid_in),
        .ready_out(ready_out), .pixel_out(pixel_out), .valid_out(valid_out),
        .ready_in(ready_in), .frame_done(frame_done), .sat_count(sat_count),
        .clear_stats(clear_stats)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [IN_W-1:0] pix;
        logic [7:0]      exp;
    } vec_t;

    typedef struct {
        logic [7:0] exp;
        int         acc;
    } sb_t;

    vec_t tbl [8];
    vec_t src [$];
    sb_t  sb  [$];

    int n_vec = 0;
    int n_err = 0;
    int xfer_count  = 0;
    int xfer_target = -1;
    int target_cyc  = -1;
    int fd_count    = 0;
    int fd_cyc      = -1;
    bit lat_chk     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Observes handshakes at the falling edge; the following rising edge
    // is where they take effect.
    task automatic monitor();
        if (valid_out && ready_in) begin
            xfer_count++;
            if (xfer_count == xfer_target) target_cyc = cyc;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got pixel 0x%0h, expected no output (cycle %0d)", pixel_out, cyc);
            end else begin
                chk("pixel_out", {24'd0, pixel_out}, {24'd0, sb[0].exp});
                if (lat_chk) chk("latency", 32'(cyc - sb[0].acc), 32'd2);
                void'(sb.pop_front());
            end
        end
        if (frame_done) begin
            fd_count++;
            fd_cyc = cyc;
        end
        if (valid_in && ready_out && src.size() > 0) begin
            sb.push_back('{src[0].exp, cyc});
            void'(src.pop_front());
        end
    endtask

    task automatic drive_src();
        if (src.size() > 0) begin
            valid_in = 1'b1;
            pixel_in = src[0].pix;
        end else begin
            valid_in = 1'b0;
        end
    endtask

    // One full clock: drive, observe at negedge, land #1 after next posedge.
    task automatic cycle();
        drive_src();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((src.size() > 0 || sb.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        if (src.size() > 0 || sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d items still pending, expected 0", src.size() + sb.size());
            src = {};
            sb  = {};
        end
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        valid_in    = 1'b0;
        pixel_in    = '0;
        ready_in    = 1'b1;
        clear_stats = 1'b0;
        src = {};
        sb  = {};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int   fd_base;
        int   x_base;
        int   n;
        bit   cleared;
        logic [7:0] held_pix;
        logic       held_v;

        tbl[0] = '{18'h00040, 8'd0};
        tbl[1] = '{18'h00080, 8'd1};
        tbl[2] = '{18'h04000, 8'd64};
        tbl[3] = '{18'h04080, 8'd65};
        tbl[4] = '{18'h3FF00, 8'd0};
        tbl[5] = '{18'h12C00, 8'd255};
        tbl[6] = '{18'h0FF7F, 8'd255};
        tbl[7] = '{18'h0FF80, 8'd255};

        // Reset state
        do_reset();
        chk("rst_pixel_out",  {24'd0, pixel_out}, 32'd0);
        chk("rst_valid_out",  {31'd0, valid_out}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_sat_count",  {16'd0, sat_count}, 32'd0);
        chk("rst_ready_out",  {31'd0, ready_out}, 32'd1);

        // In-range rounding, then clamping cases, with latency checked
        lat_chk = 1'b1;
        for (int i = 0; i < 4; i++) src.push_back(tbl[i]);
        drain(20);
        chk("sat_after_inrange", {16'd0, sat_count}, 32'd0);
        for (int i = 4; i < 8; i++) src.push_back(tbl[i]);
        drain(20);
        chk("sat_after_clamp", {16'd0, sat_count}, 32'd3);
        lat_chk = 1'b0;

        // Backpressure: 5 stalled cycles mid-stream
        x_base = xfer_count;
        for (int i = 0; i < 10; i++) src.push_back('{18'(i * 256 + 128), 8'(i + 1)});
        held_pix = '0;
        held_v   = 1'b0;
        for (int k = 0; k < 60 && (k < 10 || src.size() > 0 || sb.size() > 0); k++) begin
            ready_in = (k >= 4 && k <= 8) ? 1'b0 : 1'b1;
            drive_src();
            @(negedge clk);
            monitor();
            if (k == 4) begin
                held_pix = pixel_out;
                held_v   = valid_out;
                chk("stall_valid", {31'd0, valid_out}, 32'd1);
            end
            if (k > 4 && k <= 8) begin
                chk("stall_pixel_hold", {24'd0, pixel_out}, {24'd0, held_pix});
                chk("stall_valid_hold", {31'd0, valid_out}, {31'd0, held_v});
            end
            if (k >= 4 && k <= 8) chk("stall_ready_out", {31'd0, ready_out}, 32'd0);
            @(posedge clk);
            #1;
        end
        ready_in = 1'b1;
        chk("stall_pending", 32'(src.size() + sb.size()), 32'd0);
        chk("stall_xfers", 32'(xfer_count - x_base), 32'd10);
        src = {};
        sb  = {};

        // Frame boundary: 784 transfers then one more
        do_reset();
        fd_base     = fd_count;
        xfer_target = xfer_count + FRAME_PIXELS;
        for (int i = 0; i < FRAME_PIXELS; i++) src.push_back('{18'h00000, 8'd0});
        drain(FRAME_PIXELS + 50);
        idle(3);
        chk("frame_done_count", 32'(fd_count - fd_base), 32'd1);
        chk("frame_done_timing", 32'(fd_cyc), 32'(target_cyc + 1));
        src.push_back('{18'h00000, 8'd0});
        drain(20);
        idle(3);
        chk("no_frame_done_785", 32'(fd_count - fd_base), 32'd1);

        // Clear in the same cycle as a saturated output transfer
        x_base = xfer_count;
        src.push_back('{18'h12C00, 8'd255});
        src.push_back('{18'h3FF00, 8'd0});
        cleared = 1'b0;
        n = 0;
        while ((src.size() > 0 || sb.size() > 0) && n < 20) begin
            drive_src();
            @(negedge clk);
            monitor();
            if (!cleared && (xfer_count - x_base) == 2) begin
                chk("sat_before_clear", {16'd0, sat_count}, 32'd1);
                clear_stats = 1'b1;
                cleared     = 1'b1;
            end
            @(posedge clk);
            #1;
            clear_stats = 1'b0;
            n++;
        end
        chk("clear_seen", {31'd0, cleared}, 32'd1);
        chk("sat_after_clear", {16'd0, sat_count}, 32'd0);
        fd_base     = fd_count;
        xfer_target = xfer_count + FRAME_PIXELS;
        src.push_back('{18'h3FF00, 8'd0});
        for (int i = 1; i < FRAME_PIXELS; i++) src.push_back('{18'h00000, 8'd0});
        drain(FRAME_PIXELS + 50);
        idle(3);
        chk("sat_restart", {16'd0, sat_count}, 32'd1);
        chk("frame_after_clear_count", 32'(fd_count - fd_base), 32'd1);
        chk("frame_after_clear_timing", 32'(fd_cyc), 32'(target_cyc + 1));

        // Asynchronous reset with two pixels in flight
        src.push_back('{18'h04000, 8'd64});
        src.push_back('{18'h04080, 8'd65});
        n = 0;
        while (sb.size() < 2 && n < 10) begin
            cycle();
            n++;
        end
        drive_src();
        chk("inflight_valid", {31'd0, valid_out}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, valid_out}, 32'd0);
        chk("async_rst_pixel", {24'd0, pixel_out}, 32'd0);
        src = {};
        sb  = {};
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("post_rst_valid", {31'd0, valid_out}, 32'd0);
        end
        x_base = xfer_count;
        src.push_back('{18'h04000, 8'd64});
        drain(20);
        chk("post_rst_xfers", 32'(xfer_count - x_base), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
